uart_tx_ctrl: RTL

Frame controller for the UART transmitter, directly downstream of the serializer. It accepts a transmit request, sequences start, data, optional parity and stop bits, and drives the serializer enable and busy lines. It muxes the serial data bit, computed parity and fixed line levels onto TX_OUT. One CLK cycle equals one bit period; baud-tick generation is upstream.

---
 rtl/uart_tx_pkg.sv | 19 +
 rtl/uart_tx_ctrl_parity_calc.sv | 20 ++
 rtl/uart_tx_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and line-level constants for the UART transmit frame controller.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_ctrl_parity_calc.sv
// Combinational parity of the transmit word; odd parity is the inverted XOR reduction.
module parity_calc
    import uart_tx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic             par_typ,
    output logic             parity
);

    always_comb begin
        if (par_typ == PAR_ODD) begin
            parity = ~^data;
        end else begin
            parity = ^data;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART frame controller: sequences start, data, optional parity and stop bits around
// an external serializer and muxes the line level onto TX_OUT.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int STOP_BITS = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] P_DATA,
    input  logic             Data_Valid,
    input  logic             PAR_EN,
    input  logic             PAR_TYP,
    input  logic             ser_out,
    input  logic             ser_done,
    output logic             ser_en,
    output logic             busy,
    output logic             TX_OUT
);

    localparam logic STOP_LAST = (STOP_BITS == 2);

    tx_state_e state_reg;
    tx_state_e state_next;
    logic      stop_cnt_reg;
    logic      stop_cnt_next;
    logic      par_en_reg;
    logic      parity_reg;
    logic      parity_in;
    logic      accept;

    parity_calc #(
        .WIDTH (WIDTH)
    ) u_parity_calc (
        .data    (P_DATA),
        .par_typ (PAR_TYP),
        .parity  (parity_in)
    );

    assign accept = (state_reg == IDLE) && Data_Valid;

    // The parity type only matters at acceptance, so its effect lives in parity_reg.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg    <= IDLE;
            stop_cnt_reg <= 1'b0;
            par_en_reg   <= 1'b0;
            parity_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            stop_cnt_reg <= stop_cnt_next;
            if (accept) begin
                par_en_reg <= PAR_EN;
                parity_reg <= parity_in;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        stop_cnt_next = stop_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (Data_Valid) begin
                    state_next = START;
                end
            end
            START: begin
                state_next = DATA;
            end
            DATA: begin
                if (ser_done) begin
                    if (par_en_reg) begin
                        state_next = PARITY;
                    end else begin
                        state_next    = STOP;
                        stop_cnt_next = 1'b0;
                    end
                end
            end
            PARITY: begin
                state_next    = STOP;
                stop_cnt_next = 1'b0;
            end
            STOP: begin
                if (stop_cnt_reg == STOP_LAST) begin
                    state_next = IDLE;
                end else begin
                    stop_cnt_next = stop_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Moore output decode; TX_OUT selects only registered sources.
    always_comb begin
        TX_OUT = LINE_IDLE;
        busy   = 1'b1;
        ser_en = 1'b0;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
            end
            START: begin
                TX_OUT = START_BIT;
            end
            DATA: begin
                TX_OUT = ser_out;
                ser_en = 1'b1;
            end
            PARITY: begin
                TX_OUT = parity_reg;
            end
            STOP: begin
                TX_OUT = STOP_BIT;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
